// File: rtl/matrix_scan_driver_if.sv
// Write port of the LED matrix scan driver: a writer pushes one row pattern
// per valid/ready handshake into the back frame bank.
interface matrix_scan_driver_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    logic                      wr_valid;
    logic                      wr_ready;
    logic [$clog2(ROWS)-1:0]   wr_row;
    logic [COLS-1:0]           wr_data;

    modport master (
        output wr_valid,
        output wr_row,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_row,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/matrix_scan_driver.sv
// Double-buffered 8x8 LED matrix scanner: rows are lit one at a time with a
// blanking gap between rows; front/back banks swap only at the frame wrap.
module matrix_scan_driver #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int DIV   = 1000,
    parameter int BLANK = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    matrix_scan_driver_if.slave      wr,
    input  logic                     swap,
    output logic                     swap_done,
    output logic [$clog2(ROWS)-1:0]  row,
    output logic [ROWS-1:0]          row_sel,
    output logic [COLS-1:0]          col,
    output logic                     frame_start
);

    localparam int RW   = $clog2(ROWS);
    localparam int CMAX = (DIV > BLANK) ? DIV : BLANK;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic {
        ST_BLANK   = 1'b0,
        ST_DISPLAY = 1'b1
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [RW-1:0]   row_r;
    logic            front_r;
    logic            swap_pend_r;
    logic            swap_done_r;
    logic            frame_start_r;
    logic [COLS-1:0] bank_r [2][ROWS];

    logic            dwell_end_s;
    logic            blank_end_s;
    logic            wrap_s;
    logic            wr_fire_s;
    logic [RW-1:0]   row_next_s;
    logic [ROWS-1:0] row_sel_s;
    logic [COLS-1:0] col_s;

    // Dwell/blank terminal counts, the frame wrap and the accepted-write strobe.
    always_comb begin
        dwell_end_s = (state_r == ST_DISPLAY) && (cnt_r == CW'(DIV - 1));
        blank_end_s = (state_r == ST_BLANK) && (cnt_r == CW'(BLANK - 1));
        wrap_s      = dwell_end_s && (row_r == RW'(ROWS - 1));
        wr_fire_s   = wr.wr_valid && wr.wr_ready && (int'(wr.wr_row) < ROWS);
        if (row_r == RW'(ROWS - 1)) begin
            row_next_s = {RW{1'b0}};
        end else begin
            row_next_s = row_r + RW'(1);
        end
    end

    // Scan FSM: BLANK gap, then DISPLAY dwell, then advance to the next row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_BLANK;
            cnt_r         <= {CW{1'b0}};
            row_r         <= {RW{1'b0}};
            frame_start_r <= 1'b0;
        end else begin
            case (state_r)
                ST_BLANK: begin
                    if (blank_end_s) begin
                        state_r       <= ST_DISPLAY;
                        cnt_r         <= {CW{1'b0}};
                        frame_start_r <= (row_r == {RW{1'b0}});
                    end else begin
                        cnt_r         <= cnt_r + CW'(1);
                        frame_start_r <= 1'b0;
                    end
                end
                ST_DISPLAY: begin
                    frame_start_r <= 1'b0;
                    if (dwell_end_s) begin
                        state_r <= ST_BLANK;
                        cnt_r   <= {CW{1'b0}};
                        row_r   <= row_next_s;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r       <= ST_BLANK;
                    cnt_r         <= {CW{1'b0}};
                    row_r         <= {RW{1'b0}};
                    frame_start_r <= 1'b0;
                end
            endcase
        end
    end

    // Swap request latch; a swap arriving on the wrap edge itself is honoured there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            front_r     <= 1'b0;
            swap_pend_r <= 1'b0;
            swap_done_r <= 1'b0;
        end else if (wrap_s && (swap_pend_r || swap)) begin
            front_r     <= ~front_r;
            swap_pend_r <= 1'b0;
            swap_done_r <= 1'b1;
        end else begin
            swap_done_r <= 1'b0;
            if (swap) begin
                swap_pend_r <= 1'b1;
            end
        end
    end

    // Frame banks; writes always target the bank that is not being shown.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    bank_r[b][r] <= {COLS{1'b0}};
                end
            end
        end else if (wr_fire_s) begin
            bank_r[~front_r][wr.wr_row] <= wr.wr_data;
        end
    end

    // Row enable and column drive are decoded straight from registered state.
    always_comb begin
        row_sel_s = {ROWS{1'b0}};
        col_s     = {COLS{1'b0}};
        if (state_r == ST_DISPLAY) begin
            row_sel_s = {{(ROWS-1){1'b0}}, 1'b1} << row_r;
            col_s     = bank_r[front_r][row_r];
        end else begin
            row_sel_s = {ROWS{1'b0}};
            col_s     = {COLS{1'b0}};
        end
    end

    assign wr.wr_ready  = ~swap_pend_r;
    assign swap_done    = swap_done_r;
    assign frame_start  = frame_start_r;
    assign row          = row_r;
    assign row_sel      = row_sel_s;
    assign col          = col_s;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver with DIV=4, BLANK=2 (row period 6,
// frame period 48); samples and drives on the falling clock edge.
module tb_matrix_scan_driver;

    logic       clk;
    logic       rst;
    logic       swap;
    logic       swap_done;
    logic [2:0] row;
    logic [7:0] row_sel;
    logic [7:0] col;
    logic       frame_start;

    int n_checks;
    int n_fail;
    int cyc;

    localparam logic [7:0] T1_SEL [9] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01,
                                         8'h01, 8'h00, 8'h00, 8'h02};

    matrix_scan_driver_if #(.ROWS(8), .COLS(8)) wr_if ();

    matrix_scan_driver #(
        .ROWS  (8),
        .COLS  (8),
        .DIV   (4),
        .BLANK (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr          (wr_if),
        .swap        (swap),
        .swap_done   (swap_done),
        .row         (row),
        .row_sel     (row_sel),
        .col         (col),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto_cyc(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst      = 1'b0;
        swap     = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_row   = 3'd0;
        wr_if.wr_data  = 8'h00;
        repeat (3) @(negedge clk);

        check_eq("rst_row_sel", 32'(row_sel), 32'h0);
        check_eq("rst_col", 32'(col), 32'h0);
        check_eq("rst_swap_done", 32'(swap_done), 32'h0);
        check_eq("rst_frame_start", 32'(frame_start), 32'h0);
        check_eq("rst_wr_ready", 32'(wr_if.wr_ready), 32'h1);

        rst = 1'b1;
        cyc = 0;

        // Test 1: first rows after reset release
        for (int i = 0; i < 9; i++) begin
            goto_cyc(i);
            check_eq("t1_row_sel", 32'(row_sel), 32'(T1_SEL[i]));
            check_eq("t1_frame_start", 32'(frame_start), (i == 2) ? 32'h1 : 32'h0);
        end

        // Test 2: write into back bank, invisible until swap
        goto_cyc(9);
        check_eq("t2_wr_ready", 32'(wr_if.wr_ready), 32'h1);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_row   = 3'd3;
        wr_if.wr_data  = 8'hA5;
        tick();
        wr_if.wr_valid = 1'b0;
        goto_cyc(20);
        check_eq("t2_row3_sel", 32'(row_sel), 32'h08);
        check_eq("t2_row3_col_pre", 32'(col), 32'h00);
        goto_cyc(21);
        swap = 1'b1;
        tick();
        swap = 1'b0;
        check_eq("t2_ready_pend", 32'(wr_if.wr_ready), 32'h0);
        goto_cyc(47);
        check_eq("t2_ready_prewrap", 32'(wr_if.wr_ready), 32'h0);
        check_eq("t2_done_prewrap", 32'(swap_done), 32'h0);
        goto_cyc(48);
        check_eq("t2_swap_done", 32'(swap_done), 32'h1);
        check_eq("t2_ready_post", 32'(wr_if.wr_ready), 32'h1);
        goto_cyc(49);
        check_eq("t2_done_pulse", 32'(swap_done), 32'h0);
        goto_cyc(50);
        check_eq("t2_frame_start", 32'(frame_start), 32'h1);
        check_eq("t2_row0_sel", 32'(row_sel), 32'h01);
        goto_cyc(68);
        check_eq("t2_row3_sel_f1", 32'(row_sel), 32'h08);
        check_eq("t2_row3_col_post", 32'(col), 32'hA5);

        // Test 3: write held while swap pending
        goto_cyc(70);
        swap = 1'b1;
        tick();
        swap = 1'b0;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_row   = 3'd2;
        wr_if.wr_data  = 8'h3C;
        goto_cyc(72);
        check_eq("t3_ready_blocked", 32'(wr_if.wr_ready), 32'h0);
        goto_cyc(95);
        check_eq("t3_ready_prewrap", 32'(wr_if.wr_ready), 32'h0);
        goto_cyc(96);
        check_eq("t3_swap_done", 32'(swap_done), 32'h1);
        check_eq("t3_ready_post", 32'(wr_if.wr_ready), 32'h1);
        tick();
        wr_if.wr_row  = 3'd5;
        wr_if.wr_data = 8'h5A;
        tick();
        wr_if.wr_valid = 1'b0;
        goto_cyc(110);
        check_eq("t3_row2_sel", 32'(row_sel), 32'h04);
        check_eq("t3_row2_col_f2", 32'(col), 32'h00);
        goto_cyc(116);
        check_eq("t3_row3_col_f2", 32'(col), 32'h00);
        goto_cyc(120);
        swap = 1'b1;
        tick();
        swap = 1'b0;
        goto_cyc(144);
        check_eq("t3_swap_done2", 32'(swap_done), 32'h1);
        goto_cyc(158);
        check_eq("t3_row2_col_f3", 32'(col), 32'h3C);
        goto_cyc(164);
        check_eq("t3_row3_col_f3", 32'(col), 32'hA5);
        goto_cyc(176);
        check_eq("t3_row5_sel", 32'(row_sel), 32'h20);
        check_eq("t3_row5_col_f3", 32'(col), 32'h5A);

        // Test 4: swap on the exact wrap edge
        goto_cyc(191);
        check_eq("t4_ready", 32'(wr_if.wr_ready), 32'h1);
        check_eq("t4_row7_sel", 32'(row_sel), 32'h80);
        swap = 1'b1;
        tick();
        swap = 1'b0;
        check_eq("t4_swap_done", 32'(swap_done), 32'h1);
        goto_cyc(194);
        check_eq("t4_frame_start", 32'(frame_start), 32'h1);
        goto_cyc(200);
        swap = 1'b1;
        tick();
        swap = 1'b0;
        goto_cyc(206);
        check_eq("t4_row2_col_f4", 32'(col), 32'h00);
        goto_cyc(224);
        check_eq("t4_row5_sel_f4", 32'(row_sel), 32'h20);
        check_eq("t4_row5_col_f4", 32'(col), 32'h00);
        goto_cyc(240);
        check_eq("t4_swap_done2", 32'(swap_done), 32'h1);

        // Test 5: reset mid-DISPLAY of row 5
        goto_cyc(260);
        swap = 1'b1;
        tick();
        swap = 1'b0;
        goto_cyc(273);
        check_eq("t5_row5_sel", 32'(row_sel), 32'h20);
        check_eq("t5_row5_col", 32'(col), 32'h5A);
        check_eq("t5_ready_pend", 32'(wr_if.wr_ready), 32'h0);
        rst = 1'b0;
        #1;
        check_eq("t5_rst_row_sel", 32'(row_sel), 32'h00);
        check_eq("t5_rst_col", 32'(col), 32'h00);
        check_eq("t5_rst_ready", 32'(wr_if.wr_ready), 32'h1);
        check_eq("t5_rst_frame_start", 32'(frame_start), 32'h0);
        check_eq("t5_rst_row", 32'(row), 32'h0);
        tick();
        tick();
        rst = 1'b1;
        cyc = 0;

        // Test 6: two full frames after reset, both banks cleared
        for (int i = 0; i < 96; i++) begin
            goto_cyc(i);
            check_eq("t6_row_sel", 32'(row_sel),
                     ((i % 6) >= 2) ? (32'd1 << ((i / 6) % 8)) : 32'd0);
            check_eq("t6_row", 32'(row), 32'((i / 6) % 8));
            check_eq("t6_frame_start", 32'(frame_start), ((i % 48) == 2) ? 32'h1 : 32'h0);
            check_eq("t6_col", 32'(col), 32'h0);
            check_eq("t6_swap_done", 32'(swap_done), (i == 48) ? 32'h1 : 32'h0);
            check_eq("t6_wr_ready", 32'(wr_if.wr_ready), (i >= 11 && i < 48) ? 32'h0 : 32'h1);
            swap = (i == 10);
        end
        swap = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
